// File: rtl/register_bank_fsel_pkg.sv
// Shared definitions for the function-select register bank: FunSel codes
// and the parameter legality check used at elaboration.
package register_bank_fsel_pkg;

    localparam logic [2:0] FS_DEC  = 3'b000;  // R - 1 (wrap or saturate at 0)
    localparam logic [2:0] FS_INC  = 3'b001;  // R + 1 (wrap or saturate at all-ones)
    localparam logic [2:0] FS_LOAD = 3'b010;  // R = I
    localparam logic [2:0] FS_CLR  = 3'b011;  // R = 0, overflow flag cleared
    localparam logic [2:0] FS_LDL1 = 3'b100;  // R = zero-extended low lane
    localparam logic [2:0] FS_LDL2 = 3'b101;  // R = zero-extended low two lanes
    localparam logic [2:0] FS_SHL  = 3'b110;  // R = {R minus top lane, low lane of I}
    localparam logic [2:0] FS_SEXT = 3'b111;  // R = sign-extended low two lanes

    // True when the geometry supports lane loads, shift-in and sign extension.
    function automatic bit fsel_params_ok(int width, int lane, int nreg);
        return (lane > 0) && (width % lane == 0) && (width >= 2 * lane) && (nreg >= 2);
    endfunction

endpackage

// File: rtl/register_bank_fsel_cell.sv
// One bank register plus its sticky overflow flag. Computes the next value
// for the shared FunSel and commits it only when this cell is enabled.
module fsel_reg_cell
    import register_bank_fsel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] I,
    input  logic             en,
    input  logic [2:0]       FunSel,
    input  logic             Sat,
    output logic [WIDTH-1:0] Q,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_val;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next;
    logic             w_set_ovf;
    logic             w_clr_ovf;

    // Next-value decode; the boundary cases of inc/dec raise the overflow flag.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_next    = r_val;
        w_set_ovf = 1'b0;
        w_clr_ovf = 1'b0;
        case (FunSel)
            FS_DEC: begin
                if (r_val == '0) begin
                    w_set_ovf = 1'b1;
                    w_next    = Sat ? '0 : '1;
                end else begin
                    w_next = r_val - ONE;
                end
            end
            FS_INC: begin
                if (r_val == '1) begin
                    w_set_ovf = 1'b1;
                    w_next    = Sat ? '1 : '0;
                end else begin
                    w_next = r_val + ONE;
                end
            end
            FS_LOAD: w_next = I;
            FS_CLR: begin
                w_next    = '0;
                w_clr_ovf = 1'b1;
            end
            FS_LDL1: begin
                w_next            = '0;
                w_next[LANE-1:0]  = I[LANE-1:0];
            end
            FS_LDL2: begin
                w_next             = '0;
                w_next[2*LANE-1:0] = I[2*LANE-1:0];
            end
            FS_SHL: w_next = {r_val[WIDTH-LANE-1:0], I[LANE-1:0]};
            FS_SEXT: begin
                // Fill with the sign bit, then overlay the low two lanes.
                w_next             = {WIDTH{I[2*LANE-1]}};
                w_next[2*LANE-1:0] = I[2*LANE-1:0];
            end
            default: w_next = r_val;
        endcase
    end

    // State register with synchronous reset; disabled cells hold value and flag.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!Reset_n) begin
            r_val <= '0;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_val <= w_next;
            if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end else if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign Q   = r_val;
    assign Ovf = r_ovf;

endmodule

// File: rtl/register_bank_fsel.sv
// Bank of NREG function-select registers sharing one write bus and FunSel,
// with a per-register enable mask and two combinational read ports.
module register_bank_fsel
    import register_bank_fsel_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREG  = 4,
    parameter  int LANE  = 8,
    localparam int SELW  = $clog2(NREG)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] I,
    input  logic [NREG-1:0]  E,
    input  logic [2:0]       FunSel,
    input  logic             Sat,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic             ZeroA,
    output logic [NREG-1:0]  Ovf
);

    localparam int NSEL = 2 ** SELW;

    if (!fsel_params_ok(WIDTH, LANE, NREG)) begin : g_param_err
        $error("register_bank_fsel: WIDTH must be a multiple of LANE and >= 2*LANE, NREG >= 2");
    end

    // Read table padded to the full select range; unused selects read zero.
    logic [WIDTH-1:0] w_rd [NSEL];

    for (genvar k = 0; k < NSEL; k++) begin : g_reg
        if (k < NREG) begin : g_cell
            fsel_reg_cell #(
                .WIDTH (WIDTH),
                .LANE  (LANE)
            ) u_cell (
                .Clock   (Clock),
                .Reset_n (Reset_n),
                .I       (I),
                .en      (E[k]),
                .FunSel  (FunSel),
                .Sat     (Sat),
                .Q       (w_rd[k]),
                .Ovf     (Ovf[k])
            );
        end else begin : g_pad
            assign w_rd[k] = '0;
        end
    end

    assign OutA  = w_rd[OutASel];
    assign OutB  = w_rd[OutBSel];
    assign ZeroA = (OutA == '0);

endmodule
